vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//   Parametrised raster timing generator and pixel pipeline aligner for the VGA output path.
//   Generates h/v counters, sync pulses, data-enable and frame/line strobes for any mode.
//   Issues pixel-coordinate requests to the pixel source (snake/playfield renderer).
//   Returns the source's RGB, re-registered and blanked, with sync/DE delayed to match.
//   Sits between the pixel source and the board VGA pins; replaces the fixed 640x480 generator.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch (pixels)
//   H_SYNC    96   horizontal sync width (pixels)
//   H_BP      48   horizontal back porch (pixels)
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vertical sync width (lines)
//   V_BP      33   vertical back porch (lines)
//   HS_POL    0    hsync active level (0 = active-low)
//   VS_POL    0    vsync active level
//   COLOR_W   4    bits per colour channel
//   PIPE_LAT  1    pixel-source latency, request to rgb_in valid (cycles, >=0)
//   Derived: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise;
//     CW = $clog2(max(H_TOTAL,V_TOTAL)); LAT_OUT = PIPE_LAT+1.
// PORTS
//   clk25        in   1          pixel clock, all logic on rising edge
//   rst_n        in   1          asynchronous, active-low reset
//   en           in   1          advance enable; 0 freezes the entire block
//   pix_x        out  CW         requested column (= h counter)
//   pix_y        out  CW         requested row (= v counter)
//   pix_req      out  1          1 when (pix_x,pix_y) is in the active area
//   rgb_in       in   3*COLOR_W  {red,green,blue} from source, PIPE_LAT cycles after request
//   red_out      out  COLOR_W    registered red, 0 outside active area
//   green_out    out  COLOR_W    registered green
//   blue_out     out  COLOR_W    registered blue
//   hSync        out  1          horizontal sync, polarity HS_POL
//   vSync        out  1          vertical sync, polarity VS_POL
//   de           out  1          data enable, aligned with rgb outputs
//   frame_start  out  1          1-cycle pulse, request side, at h=0,v=0
//   line_start   out  1          1-cycle pulse, request side, at h=0 (every line)
// BEHAVIOUR
//   - Reset (async, rst_n=0): counters 0, pipeline cleared to blank; rgb outputs 0;
//     de=0; hSync=~HS_POL; vSync=~VS_POL; pix_req=0; strobes 0.
//   - Counters registered: h wraps H_TOTAL-1 -> 0; v increments only on h wrap, V_TOTAL-1 -> 0.
//   - Request side (cycle 0): pix_x/pix_y = counters; pix_req = h<H_ACTIVE && v<V_ACTIVE.
//     frame_start = en && h==0 && v==0; line_start = en && h==0.
//   - hs_raw active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//   - vs_raw active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; edges coincide with h=0.
//   - hs_raw, vs_raw, pix_req pass through a PIPE_LAT-deep shift register; output
//     stage registers rgb_in (masked to 0 when delayed pix_req=0) together with them.
//   - Net: hSync/vSync/de/rgb lag the request counters by exactly LAT_OUT cycles.
//   - en=0: counters, shift register and output registers all hold; strobes 0.
//     Alignment is preserved across any pause.
//   - Reset mid-frame: outputs return to reset values at once; first frame after
//     release starts at h=0,v=0 with frame_start on the first enabled cycle.
//   - Widths: counter compare in CW bits, no overflow; rgb_in upper bits ignored
//     beyond 3*COLOR_W; COLOR_W change only widens data paths.
// TESTING (defaults unless stated; H_TOTAL=800, V_TOTAL=525, LAT_OUT=2)
//   1 Reset release, en=1 -> hSync low exactly 96 of every 800 cycles; first fall
//     656+2 cycles after first enabled edge.
//   2 Run 2 frames -> vSync low 1600 cycles starting line 490; frame period 420000;
//     frame_start once per frame; line_start once per 800 cycles.
//   3 Source returns rgb={x[3:0],y[3:0],x[7:4]} after 1 cycle -> de high 640 cyc/line,
//     480 lines/frame; rgb matches model; rgb=0 whenever de=0.
//   4 en=0 for 37 cycles at h=300 -> all outputs frozen; after resume, all timing
//     shifted by exactly 37 cycles; alignment holds.
//   5 rst_n pulsed low at h=300,v=200 -> outputs at reset values asynchronously;
//     restart from 0,0; vSync and hSync held inactive during reset.
//   6 H=8/2/2/2, V=4/1/1/1, HS_POL=VS_POL=1, PIPE_LAT=3 -> line 14 cycles,
//     frame 98 cycles; syncs active-high; outputs lag 4 cycles.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator and pixel pipeline aligner.
// Counters drive pixel-coordinate requests; sync/DE travel through a delay line
// matched to the pixel source latency, then register together with the
// returned RGB so that every output lags the request side by PIPE_LAT+1 cycles.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int PIPE_LAT = 1,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int CW      = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL)
) (
    input  logic                 clk25,
    input  logic                 rst_n,
    input  logic                 en,
    output logic [CW-1:0]        pix_x,
    output logic [CW-1:0]        pix_y,
    output logic                 pix_req,
    input  logic [3*COLOR_W-1:0] rgb_in,
    output logic [COLOR_W-1:0]   red_out,
    output logic [COLOR_W-1:0]   green_out,
    output logic [COLOR_W-1:0]   blue_out,
    output logic                 hSync,
    output logic                 vSync,
    output logic                 de,
    output logic                 frame_start,
    output logic                 line_start
);

    // Compares run one bit wider than the counters so a sync end equal to
    // 2**CW cannot wrap to zero.
    localparam int XW = CW + 1;
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] V_LAST   = XW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] V_ACT    = XW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_BEGIN = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] VS_BEGIN = XW'(V_ACTIVE + V_FP);
    localparam logic [XW-1:0] VS_END   = XW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0]      r_h;
    logic [CW-1:0]      r_v;
    logic [XW-1:0]      w_h;
    logic [XW-1:0]      w_v;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_active;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic               w_hs_d;
    logic               w_vs_d;
    logic               w_req_d;
    logic               r_hs;
    logic               r_vs;
    logic               r_de;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;

    assign w_h      = {1'b0, r_h};
    assign w_v      = {1'b0, r_v};
    assign w_h_wrap = (w_h == H_LAST);
    assign w_v_wrap = (w_v == V_LAST);
    assign w_active = (w_h < H_ACT) && (w_v < V_ACT);
    assign w_hs_raw = (w_h >= HS_BEGIN) && (w_h < HS_END);
    assign w_vs_raw = (w_v >= VS_BEGIN) && (w_v < VS_END);

    // Raster counters: h every enabled cycle, v on each h wrap
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (en) begin
            if (w_h_wrap) begin
                r_h <= '0;
                if (w_v_wrap) r_v <= '0;
                else          r_v <= r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Request-side outputs are combinational from the counters; reset masks
    // them so the request and strobes read inactive while rst_n is low.
    assign pix_x       = r_h;
    assign pix_y       = r_v;
    assign pix_req     = w_active & rst_n;
    assign line_start  = rst_n & en & (r_h == '0);
    assign frame_start = rst_n & en & (r_h == '0) & (r_v == '0);

    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign w_hs_d  = w_hs_raw;
            assign w_vs_d  = w_vs_raw;
            assign w_req_d = w_active;
        end else begin : g_dly
            logic [2:0] r_pipe [PIPE_LAT];
            for (genvar g = 0; g < PIPE_LAT; g++) begin : g_stage
                logic [2:0] w_prev;
                if (g == 0) begin : g_head
                    assign w_prev = {w_hs_raw, w_vs_raw, w_active};
                end else begin : g_body
                    assign w_prev = r_pipe[g-1];
                end
                // One delay stage of {hsync, vsync, request} matching source latency
                always_ff @(posedge clk25 or negedge rst_n) begin
                    if (!rst_n)  r_pipe[g] <= '0;
                    else if (en) r_pipe[g] <= w_prev;
                end
            end
            assign {w_hs_d, w_vs_d, w_req_d} = r_pipe[PIPE_LAT-1];
        end
    endgenerate

    // Output stage: register returned RGB with the delayed timing, blanking outside active area
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_hs    <= 1'b0;
            r_vs    <= 1'b0;
            r_de    <= 1'b0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (en) begin
            r_hs    <= w_hs_d;
            r_vs    <= w_vs_d;
            r_de    <= w_req_d;
            r_red   <= w_req_d ? rgb_in[3*COLOR_W-1:2*COLOR_W] : '0;
            r_green <= w_req_d ? rgb_in[2*COLOR_W-1:COLOR_W]   : '0;
            r_blue  <= w_req_d ? rgb_in[COLOR_W-1:0]           : '0;
        end
    end

    // Sync registers hold "active"; polarity is applied on the way out.
    assign hSync     = r_hs ? HS_POL : ~HS_POL;
    assign vSync     = r_vs ? VS_POL : ~VS_POL;
    assign de        = r_de;
    assign red_out   = r_red;
    assign green_out = r_green;
    assign blue_out  = r_blue;

endmodule
